// File: rtl/step_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : step_sched_pkg
// Brief    : Shared state encodings, source codes and width helper for the
//            step scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package step_sched_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DIR_SETUP = 2'd1;
  localparam logic [1:0] ST_STEP_HIGH = 2'd2;
  localparam logic [1:0] ST_STEP_LOW  = 2'd3;

  localparam logic SRC_AUTO = 1'b0;
  localparam logic SRC_MAN  = 1'b1;

  // Effective period is the requested word scaled by the prescaler, unsigned.
  function automatic int period_eff_width(input int width_work, input int prescale);
    return width_work + prescale;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : step_scheduler_if
// Brief    : Requester inputs and motor-pin outputs of the step scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface step_scheduler_if #(
  parameter int WIDTH_WORK = 16
);
  logic                  auto_en;
  logic [WIDTH_WORK-1:0] auto_period;
  logic                  auto_dir;
  logic                  man_en;
  logic [WIDTH_WORK-1:0] man_period;
  logic                  man_dir;
  logic                  pos_clr;
  logic                  step;
  logic                  dir;
  logic                  drv_en;
  logic                  src;
  logic signed [31:0]    pos;

  modport master (
    output auto_en, auto_period, auto_dir, man_en, man_period, man_dir, pos_clr,
    input  step, dir, drv_en, src, pos
  );

  modport slave (
    input  auto_en, auto_period, auto_dir, man_en, man_period, man_dir, pos_clr,
    output step, dir, drv_en, src, pos
  );
endinterface
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module   : step_timer
// Brief    : Loadable down-counter; done is high while the count sits at 0.
// Revision : 1.0 - initial release
// ============================================================================
module step_timer #(
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : step_scheduler
// Brief    : Arbitrates AUTO/MANUAL step requests into STEP/DIR/ENABLE pins.
//            Optional position counter enabled by STEP_POS_COUNTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module step_scheduler
  import step_sched_pkg::*;
#(
  parameter int WIDTH_WORK = 16,
  parameter int PRESCALE   = 3,
  parameter int PULSE_HIGH = 100,
  parameter int DIR_SETUP  = 250,
  parameter int MIN_PERIOD = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  step_scheduler_if.slave bus
);

  localparam int              c_PW         = period_eff_width(WIDTH_WORK, PRESCALE);
  localparam logic [c_PW-1:0] c_HIGH_LOAD  = c_PW'(PULSE_HIGH - 1);
  localparam logic [c_PW-1:0] c_SETUP_LOAD = c_PW'(DIR_SETUP - 1);
  localparam logic [c_PW-1:0] c_LOW_TRIM   = c_PW'(PULSE_HIGH + 1);
  localparam logic [c_PW-1:0] c_MIN_PERIOD = c_PW'(MIN_PERIOD);

  logic [1:0]            r_state;
  logic                  r_dir;
  logic                  r_src;
  logic [c_PW-1:0]       r_period_eff;

  logic                  w_man_v;
  logic                  w_auto_v;
  logic                  w_valid;
  logic                  w_tgt_dir;
  logic                  w_tgt_src;
  logic [WIDTH_WORK-1:0] w_tgt_period;
  logic [c_PW-1:0]       w_shifted;
  logic [c_PW-1:0]       w_tgt_peff;
  logic                  w_arb;
  logic                  w_done;
  logic                  w_load;
  logic [c_PW-1:0]       w_load_val;
  logic [1:0]            w_next_state;

  assign w_man_v      = bus.man_en  && (bus.man_period  != '0);
  assign w_auto_v     = bus.auto_en && (bus.auto_period != '0);
  assign w_valid      = w_man_v || w_auto_v;
  assign w_tgt_src    = w_man_v ? SRC_MAN : SRC_AUTO;
  assign w_tgt_dir    = w_man_v ? bus.man_dir : bus.auto_dir;
  assign w_tgt_period = w_man_v ? bus.man_period : bus.auto_period;
  assign w_shifted    = {w_tgt_period, {PRESCALE{1'b0}}};
  assign w_tgt_peff   = (w_shifted < c_MIN_PERIOD) ? c_MIN_PERIOD : w_shifted;

  // Requests are only looked at while idle or at the close of a full period.
  assign w_arb = (r_state == ST_IDLE) || ((r_state == ST_STEP_LOW) && w_done);

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE, ST_STEP_LOW: begin
        if (w_arb) begin
          if (!w_valid) begin
            w_next_state = ST_IDLE;
          end else if (w_tgt_dir != r_dir) begin
            w_next_state = ST_DIR_SETUP;
            w_load       = 1'b1;
            w_load_val   = c_SETUP_LOAD;
          end else begin
            w_next_state = ST_STEP_HIGH;
            w_load       = 1'b1;
            w_load_val   = c_HIGH_LOAD;
          end
        end
      end
      ST_DIR_SETUP: begin
        if (w_done) begin
          w_next_state = ST_STEP_HIGH;
          w_load       = 1'b1;
          w_load_val   = c_HIGH_LOAD;
        end
      end
      ST_STEP_HIGH: begin
        if (w_done) begin
          w_next_state = ST_STEP_LOW;
          w_load       = 1'b1;
          w_load_val   = r_period_eff - c_LOW_TRIM;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  step_timer #(
    .WIDTH (c_PW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dir        <= 1'b0;
      r_src        <= SRC_AUTO;
      r_period_eff <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_arb && w_valid) begin
        r_src        <= w_tgt_src;
        r_dir        <= w_tgt_dir;
        r_period_eff <= w_tgt_peff;
      end
    end
  end

  assign bus.step   = (r_state == ST_STEP_HIGH);
  assign bus.drv_en = (r_state != ST_IDLE);
  assign bus.dir    = r_dir;
  assign bus.src    = r_src;

`ifdef STEP_POS_COUNTER_EN
  logic               w_enter_high;
  logic signed [31:0] r_pos;

  // Any path into STEP_HIGH has DIR already settled, so r_dir is the step direction.
  assign w_enter_high = (w_next_state == ST_STEP_HIGH) && (r_state != ST_STEP_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
    end else if (bus.pos_clr) begin
      r_pos <= '0;
    end else if (w_enter_high) begin
      r_pos <= r_dir ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
    end
  end

  assign bus.pos = r_pos;
`else
  logic w_unused_pos_clr;
  assign w_unused_pos_clr = bus.pos_clr;
  assign bus.pos          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_scheduler
// Brief    : Self-checking bench for step_scheduler with a timestamp-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_scheduler;

  localparam int WW   = 16;
  localparam int PS   = 3;
  localparam int PH   = 100;
  localparam int DS   = 250;
  localparam int MINP = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  step_scheduler_if #(.WIDTH_WORK(WW)) bus ();

  step_scheduler #(
    .WIDTH_WORK (WW),
    .PRESCALE   (PS),
    .PULSE_HIGH (PH),
    .DIR_SETUP  (DS),
    .MIN_PERIOD (MINP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: each step is described by the cycle its STEP rises and the cycle
  // of the next arbitration; outputs follow from those timestamps.
  int          mt      = 0;
  bit          m_busy  = 1'b0;
  bit          m_dir   = 1'b0;
  bit          m_src   = 1'b0;
  int          m_rise  = 0;
  int          m_next  = 0;
  logic [31:0] m_pos   = '0;

  function automatic int peff_of(input int p);
    int v;
    v = p * (1 << PS);
    return (v < MINP) ? MINP : v;
  endfunction

  function automatic logic [31:0] pexp(input int v);
`ifdef STEP_POS_COUNTER_EN
    return 32'(v);
`else
    return 32'(v) & 32'd0;
`endif
  endfunction

  task automatic model_edge();
    bit man_v, auto_v;
    bit tdir;
    mt++;
    if (!m_busy || mt == m_next) begin
      man_v  = bus.man_en  && (bus.man_period  != 0);
      auto_v = bus.auto_en && (bus.auto_period != 0);
      if (!(man_v || auto_v)) begin
        m_busy = 1'b0;
      end else begin
        tdir  = man_v ? bus.man_dir : bus.auto_dir;
        m_src = man_v;
        if (tdir != m_dir) begin
          m_dir  = tdir;
          m_rise = mt + DS;
        end else begin
          m_rise = mt;
        end
        m_busy = 1'b1;
        m_next = m_rise + peff_of(int'(man_v ? bus.man_period : bus.auto_period));
      end
    end
`ifdef STEP_POS_COUNTER_EN
    if (bus.pos_clr) m_pos = '0;
    else if (m_busy && mt == m_rise) m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_dir  = 1'b0;
        m_src  = 1'b0;
        m_pos  = '0;
      end else begin
        model_edge();
      end
    end
  end

  // Per-cycle comparison of every pin against the model.
  initial begin
    logic [35:0] act, exp;
    bit          e_step;
    forever begin
      @(negedge clk);
      e_step = m_busy && (mt >= m_rise) && (mt < m_rise + PH);
      exp = {e_step, m_dir, m_busy, m_src, m_pos};
      act = {bus.step, bus.dir, bus.drv_en, bus.src, 32'(bus.pos)};
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL cycle_cmp t=%0t got step=%b dir=%b drv_en=%b src=%b pos=%0d want step=%b dir=%b drv_en=%b src=%b pos=%0d",
                 $time, act[35], act[34], act[33], act[32], $signed(act[31:0]),
                 exp[35], exp[34], exp[33], exp[32], $signed(exp[31:0]));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int budget, output int t);
    logic prev;
    prev = bus.step;
    t    = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.step && !prev) begin
        t = cyc;
        return;
      end
      prev = bus.step;
    end
    n_vec++;
    n_err++;
    $display("FAIL wait_rise timeout got=none want=rise within %0d cycles", budget);
  endtask

  task automatic set_auto(input bit en, input int p, input bit d);
    bus.auto_en     = en;
    bus.auto_period = WW'(p);
    bus.auto_dir    = d;
  endtask

  task automatic set_man(input bit en, input int p, input bit d);
    bus.man_en     = en;
    bus.man_period = WW'(p);
    bus.man_dir    = d;
  endtask

  initial begin
    int t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, tr;
    set_auto(1'b1, 100, 1'b1);
    set_man(1'b1, 50, 1'b1);
    bus.pos_clr = 1'b0;
    #3 rst_n = 1'b0;

    cycles(5);
    check("rst_step",   32'(bus.step),   32'd0);
    check("rst_dir",    32'(bus.dir),    32'd0);
    check("rst_drv_en", 32'(bus.drv_en), 32'd0);
    check("rst_src",    32'(bus.src),    32'd0);
    check("rst_pos",    32'(bus.pos),    32'd0);
    set_auto(1'b0, 0, 1'b0);
    set_man(1'b0, 0, 1'b0);
    rst_n = 1'b1;
    cycles(10);
    check("idle_drv_en", 32'(bus.drv_en), 32'd0);
    check("idle_step",   32'(bus.step),   32'd0);

    // AUTO 100 units -> 800-cycle period, no setup, negative direction.
    set_auto(1'b1, 100, 1'b0);
    wait_rise(50, t0);
    check("first_pos", 32'(bus.pos), pexp(-1));
    check("drv_en_run", 32'(bus.drv_en), 32'd1);
    cycles(99);
    check("high_last", 32'(bus.step), 32'd1);
    cycles(1);
    check("high_end", 32'(bus.step), 32'd0);
    wait_rise(900, t1);
    check("spacing_800a", 32'(t1 - t0), 32'd800);
    wait_rise(900, t2);
    check("spacing_800b", 32'(t2 - t1), 32'd800);
    check("pos_m3", 32'(bus.pos), pexp(-3));

    // Short request is clamped to the minimum period.
    set_auto(1'b1, 10, 1'b0);
    wait_rise(900, t3);
    check("clamp_boundary", 32'(t3 - t2), 32'd800);
    wait_rise(900, t4);
    check("clamp_200", 32'(t4 - t3), 32'd200);

    // Direction flip mid-pulse: period completes, then setup delay.
    set_auto(1'b1, 100, 1'b0);
    wait_rise(900, t5);
    check("back_to_800", 32'(t5 - t4), 32'd200);
    cycles(50);
    set_auto(1'b1, 100, 1'b1);
    wait_rise(1200, t6);
    check("dir_setup_1050", 32'(t6 - t5), 32'd1050);
    check("dir_now_1", 32'(bus.dir), 32'd1);
    check("pos_after_flip", 32'(bus.pos), pexp(-5));

    // MANUAL preempts at the next boundary, then hands back.
    set_man(1'b1, 50, 1'b1);
    wait_rise(900, t7);
    check("man_boundary", 32'(t7 - t6), 32'd800);
    check("src_man", 32'(bus.src), 32'd1);
    wait_rise(900, t8);
    check("man_400", 32'(t8 - t7), 32'd400);
    set_man(1'b0, 50, 1'b1);
    wait_rise(900, t9);
    check("man_last_400", 32'(t9 - t8), 32'd400);
    check("src_auto", 32'(bus.src), 32'd0);
    wait_rise(900, t10);
    check("auto_resume_800", 32'(t10 - t9), 32'd800);

    // Period 0 retires the block after the running step.
    set_auto(1'b1, 0, 1'b1);
    cycles(700);
    check("still_busy", 32'(bus.drv_en), 32'd1);
    cycles(105);
    check("stop_drv_en", 32'(bus.drv_en), 32'd0);
    check("stop_step", 32'(bus.step), 32'd0);

    // Randomized requester traffic; the per-cycle compare does the checking.
    for (int s = 0; s < 40; s++) begin
      set_auto($urandom_range(0, 3) != 0, $urandom_range(0, 40), 1'($urandom));
      set_man($urandom_range(0, 2) == 0, $urandom_range(0, 40), 1'($urandom));
      for (int c = $urandom_range(20, 700); c > 0; c--) begin
        bus.pos_clr = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      bus.pos_clr = 1'b0;
    end

    // Asynchronous reset in the middle of a STEP pulse.
    set_man(1'b0, 0, 1'b0);
    set_auto(1'b1, 20, 1'b1);
    wait_rise(3000, tr);
    cycles(10);
    #3 rst_n = 1'b0;
    #1;
    check("async_step",   32'(bus.step),   32'd0);
    check("async_pos",    32'(bus.pos),    32'd0);
    check("async_drv_en", 32'(bus.drv_en), 32'd0);
    check("async_dir",    32'(bus.dir),    32'd0);
    cycles(3);
    rst_n = 1'b1;
    cycles(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/step_scheduler.md
# step_scheduler

Step-pulse scheduler between the tracking/manual mode logic and the stepper-motor driver pins. It arbitrates two step-rate requesters, the AUTO tracking source and the MANUAL jog source, and turns the selected period/direction into STEP/DIR/ENABLE waveforms. Requester changes are applied only at step boundaries, with enforced pulse width, minimum period and direction setup time.

## Interface
- WIDTH_WORK, 16: width of requested period words
- PRESCALE, 3: requested period unit = 2^PRESCALE clk cycles
- PULSE_HIGH, 100: STEP high time, clk cycles (2 us @ 50 MHz)
- DIR_SETUP, 250: DIR-to-STEP setup time, clk cycles
- MIN_PERIOD, 200: minimum step period, clk cycles; must exceed PULSE_HIGH
- clk  in  1  50 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- auto_en  in  1  AUTO source request (tracking drive enable)
- auto_period  in  WIDTH_WORK  AUTO period, PRESCALE units; 0 = no stepping
- auto_dir  in  1  AUTO direction
- man_en  in  1  MANUAL jog request
- man_period  in  WIDTH_WORK  MANUAL period, PRESCALE units; 0 = no stepping
- man_dir  in  1  MANUAL direction
- pos_clr  in  1  synchronous position clear (STEP_POS_COUNTER_EN only)
- step  out  1  STEP pin
- dir  out  1  DIR pin
- drv_en  out  1  driver enable
- src  out  1  source owning current step: 0 AUTO, 1 MANUAL
- pos  out  32  signed step position

## Operation
- Source valid: MANUAL if man_en && man_period != 0; AUTO if auto_en && auto_period != 0. MANUAL has fixed priority.
- Arbitration happens only in IDLE and at the end of STEP_LOW. Inputs are ignored at all other times.
- At arbitration, latch the winner's src, dir target and period_eff = max(period << PRESCALE, MIN_PERIOD). period_eff is WIDTH_WORK+PRESCALE bits, unsigned.
- States:
  - IDLE: step=0, drv_en=0. If no valid source, stay. If target dir != dir, update dir and go to DIR_SETUP. Otherwise go to STEP_HIGH.
  - DIR_SETUP: step=0 for DIR_SETUP cycles, then go to STEP_HIGH.
  - STEP_HIGH: step=1 for PULSE_HIGH cycles. On entry, pos changes by +1 if dir=1, -1 if dir=0. Then go to STEP_LOW.
  - STEP_LOW: step=0 for period_eff-PULSE_HIGH cycles, then arbitrate. No valid source goes to IDLE; dir change goes to DIR_SETUP; otherwise go to STEP_HIGH.
- drv_en=1 in every state except IDLE.
- A request dropped mid-step does not truncate the step: the full period completes, then the block goes to IDLE.
- A source switch is equivalent to a new period/dir at the boundary; src updates at that boundary.
- pos_clr has priority over a same-cycle increment (pos=0). pos wraps modulo 2^32.
- Reset values: step=0, dir=0, drv_en=0, src=0, pos=0, state=IDLE, timer=0.

## Timing
- Request sampled valid at edge N in IDLE (no dir change): step=1 from edge N until edge N+PULSE_HIGH.
- Rising-to-rising STEP spacing equals exactly period_eff cycles while the source and dir are unchanged.
- Dir change: dir toggles at the arbitration edge; STEP rises exactly DIR_SETUP cycles later.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- rst_n assertion forces reset values asynchronously, including mid-pulse. Deassertion is assumed synchronized upstream.

## Configuration
- STEP_POS_COUNTER_EN defined: the 32-bit pos counter and pos_clr are implemented.
- STEP_POS_COUNTER_EN undefined: pos is tied to 0 and pos_clr is ignored; the counter logic is not synthesized.

## Structure
- Package step_sched_pkg holds:
  - state enum (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW)
  - source encoding constants SRC_AUTO/SRC_MAN
  - period_eff width localparam helper
- Sub-module step_timer: loadable down-counter, width WIDTH_WORK+PRESCALE, with load/value/done. Done asserts when the count reaches 0.
- FSM, arbitration and position counter stay in the top module.

## Test plan
- Reset: rst_n=0 with inputs active -> step=dir=drv_en=src=0, pos=0. After release with no request, all stay 0.
- auto_en=1, auto_period=100, auto_dir=0 -> no setup delay; step high 100 cycles, rising edges every 800 cycles; pos -1,-2,-3; drv_en=1.
- auto_period=10 -> period clamped to 200 cycles (high 100, low 100). auto_period=0 -> IDLE after the current step, drv_en=0.
- auto_dir 0->1 mid STEP_HIGH -> that step completes its 800-cycle period; dir=1 at the boundary; next step rises 250 cycles later; pos increments.
- man_en=1, man_period=50 while AUTO runs -> current AUTO step completes; src=1, spacing becomes 400 cycles. man_en=0 -> AUTO resumes at the next boundary, src=0.
- rst_n low mid STEP_HIGH -> step=0 and pos=0 immediately. With the macro undefined, pos stays 0 through the whole AUTO run.
